shift32_seq: RTL and testbench
==============================

Name: shift32_seq

Overview:
Multi-cycle, handshaked 32-bit logical shifter. It is the sequential counterpart of the combinational SHIFT32 and uses the same operand semantics (D, S, LnR → Y).
- Performs one log-stage per clock: stage k shifts by 2^k when S[k] is set.
- Serves datapaths that cannot afford a 5-level mux chain in a single cycle.
- Sits beside the ALU and is driven by the control unit with a START/DONE handshake.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported.
SHAMT_WIDTH, 5, number of low S bits used as the shift amount; equals log2(DATA_WIDTH).

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous, active-low reset
START  input  1  request; sampled only when BUSY=0
D  input  32  data operand; captured when a request is accepted
S  input  32  shift amount; captured when a request is accepted
LnR  input  1  1 = shift left, 0 = logical shift right; captured when a request is accepted
Y  output  32  result register; holds its value until the next completion
BUSY  output  1  high while an operation is in flight
DONE  output  1  single-cycle pulse; Y is valid in the same cycle

Behaviour:
- Reset (RST=0, asynchronous): Y=0, BUSY=0, DONE=0, state=IDLE, stage counter=0, internal working register=0.
  - Reset aborts any in-flight operation; no DONE is produced for it.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - Accept when START=1 at a rising edge. Capture D into the working register, S[4:0] into the shift-amount register, LnR, and a range flag (S[31:5]!=0). Set BUSY=1 and stage=0.
  - If the range flag is set → FINISH; otherwise → SHIFT.
- SHIFT: at each edge, if shamt[stage]=1, shift the working register by 2^stage in the captured direction and zero-fill; then stage++.
  - Stage 4 completes on the 5th edge after acceptance. On that same edge: Y<=working result, DONE<=1, BUSY<=0, state → IDLE.
- FINISH (out-of-range amount): on the first edge after acceptance, Y<=0, DONE<=1, BUSY<=0, state → IDLE.
- Latency:
  - In-range amounts, including S=0: exactly 5 cycles from the accepting edge to the DONE edge. The latency is uniform; there is no early exit.
  - Out-of-range amounts: 1 cycle.
- DONE is high for exactly one cycle, and BUSY is 0 during that cycle.
- START while BUSY=1 is ignored; input changes during BUSY have no effect.
- Back-to-back: START may be high in the DONE cycle. That request is accepted on the next edge, giving a throughput of one operation per 6 cycles (in-range).
- Right shift is logical only; there is no sign extension.
- Shift by 31 is legal. Amounts ≥ 32 always yield 0, regardless of D or LnR.
- Y changes only on a DONE edge or on reset.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and SHAMT_WIDTH constants.
  - State encodings: IDLE=2'b00, SHIFT=2'b01, FINISH=2'b10.
  - LnR encodings: SHIFT_LEFT=1, SHIFT_RIGHT=0.
- One natural sub-module: shift32_stage. It is purely combinational.
  - Inputs: the data word, a stage index, an enable bit and the direction.
  - Output: the data shifted by 2^stage when enabled, otherwise passed through.
  - Instantiated once and time-multiplexed via the stage counter.

Test Plan:
- D=0x0000_0001, LnR=1, S=0x1f, START pulse → BUSY high 5 cycles; DONE on the 5th edge; Y=0x8000_0000.
- D=0x8000_0000, LnR=0, sweep S=0x0..0x1f back-to-back (START held in each DONE cycle) → each result Y=0x8000_0000>>S, one DONE per 6 cycles; S=0 gives Y=0x8000_0000 after 5 cycles.
- Out-of-range amounts with D=0xFFFF_FFFF, each with LnR=1 and LnR=0: S=0x5f, 0x7f, 0xffff_ffe2 → DONE 1 cycle after acceptance, Y=0x0000_0000.
- START re-pulsed at cycle 2 of a busy operation with different D/S → ignored; the original result (D=0x1234_5678, S=4, LnR=1 → Y=0x2345_6780) is produced on schedule.
- RST low at cycle 3 of an operation (asynchronous, mid-cycle) → Y, BUSY and DONE drop to 0 immediately and no DONE follows. After release, a new request D=0x1, S=1, LnR=1 → Y=0x2.
- Hold check: after completion, Y stays constant for 10 idle cycles while D, S and LnR toggle randomly with START=0.

Source files
------------

// File: rtl/shift32_seq_pkg.sv
// rtl/shift32_seq_pkg.sv - shared constants and encodings for the sequential shifter
package shift32_seq_pkg;
    localparam int DATA_WIDTH  = 32;
    localparam int SHAMT_WIDTH = 5;
    localparam int STAGE_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        FINISH = 2'b10
    } state_t;

    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;
endpackage

// File: rtl/shift32_stage.sv
// rtl/shift32_stage.sv - one log-stage of the shifter: shift by 2^stage when enabled
module shift32_stage
    import shift32_seq_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [STAGE_WIDTH-1:0] stage,
    input  logic                   enable,
    input  logic                   dir,
    output logic [DATA_WIDTH-1:0]  result
);
    logic [SHAMT_WIDTH-1:0] amount;

    always_comb begin
        amount = '0;
        case (stage)
            3'd0:    amount = 5'd1;
            3'd1:    amount = 5'd2;
            3'd2:    amount = 5'd4;
            3'd3:    amount = 5'd8;
            3'd4:    amount = 5'd16;
            default: amount = 5'd0;
        endcase
        result = data;
        if (enable) begin
            if (dir == SHIFT_LEFT) result = data << amount;
            else                   result = data >> amount;
        end
    end
endmodule

// File: rtl/shift32_seq.sv
// rtl/shift32_seq.sv - multi-cycle handshaked 32-bit logical shifter, one log-stage per clock
module shift32_seq
    import shift32_seq_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] S,
    input  logic                  LnR,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  BUSY,
    output logic                  DONE
);
    state_t                 state, state_nxt;
    logic [DATA_WIDTH-1:0]  work;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   dir;
    logic [STAGE_WIDTH-1:0] stage;
    logic [DATA_WIDTH-1:0]  stage_out;
    logic                   last_stage;

    assign last_stage = (stage == 3'd4);

    shift32_stage u_stage (
        .data   (work),
        .stage  (stage),
        .enable (shamt[stage]),
        .dir    (dir),
        .result (stage_out)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Out-of-range amounts skip the stage walk entirely and force a zero result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = (|S[DATA_WIDTH-1:SHAMT_WIDTH]) ? FINISH : SHIFT;
            SHIFT:   if (last_stage) state_nxt = IDLE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Y     <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            work  <= '0;
            shamt <= '0;
            dir   <= SHIFT_RIGHT;
            stage <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        work  <= D;
                        shamt <= S[SHAMT_WIDTH-1:0];
                        dir   <= LnR;
                        stage <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                SHIFT: begin
                    work  <= stage_out;
                    stage <= stage + 3'd1;
                    if (last_stage) begin
                        Y     <= stage_out;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        stage <= '0;
                    end
                end
                FINISH: begin
                    Y    <= '0;
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                end
                default: BUSY <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_shift32_seq.sv
// tb/tb_shift32_seq.sv - directed table-driven bench for shift32_seq
module tb_shift32_seq;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [31:0] D = '0;
    logic [31:0] S = '0;
    logic        LnR = 1'b0;
    logic [31:0] Y;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int errors = 0;

    shift32_seq dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .D     (D),
        .S     (S),
        .LnR   (LnR),
        .Y     (Y),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d;
        logic [31:0] s;
        logic        lnr;
        logic [31:0] exp_y;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [31:0] d, input logic [31:0] s, input logic lnr);
        D = d; S = s; LnR = lnr; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_accept", {31'd0, BUSY}, 32'd1);
    endtask

    task automatic wait_done(input int pre, output int lat);
        lat = pre;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (DONE) break;
        end
        if (!DONE) begin
            errors++;
            $display("FAIL done_timeout: DONE not seen after %0d cycles", lat);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] d, input logic [31:0] s,
                          input logic lnr, input logic [31:0] exp_y, input int exp_lat);
        int lat;
        start_op(d, s, lnr);
        wait_done(0, lat);
        check({name, "_y"}, Y, exp_y);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_busy_at_done"}, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        logic [31:0] y_hold;
        int lat;

        vecs[0]  = '{32'h0000_0001, 32'h0000_001f, 1'b1, 32'h8000_0000, 5};
        vecs[1]  = '{32'hffff_ffff, 32'h0000_005f, 1'b1, 32'h0000_0000, 1};
        vecs[2]  = '{32'hffff_ffff, 32'h0000_005f, 1'b0, 32'h0000_0000, 1};
        vecs[3]  = '{32'hffff_ffff, 32'h0000_007f, 1'b1, 32'h0000_0000, 1};
        vecs[4]  = '{32'hffff_ffff, 32'h0000_007f, 1'b0, 32'h0000_0000, 1};
        vecs[5]  = '{32'hffff_ffff, 32'hffff_ffe2, 1'b1, 32'h0000_0000, 1};
        vecs[6]  = '{32'hffff_ffff, 32'hffff_ffe2, 1'b0, 32'h0000_0000, 1};
        vecs[7]  = '{32'ha5a5_a5a5, 32'h0000_0008, 1'b0, 32'h00a5_a5a5, 5};
        vecs[8]  = '{32'hffff_ffff, 32'h0000_001f, 1'b0, 32'h0000_0001, 5};
        vecs[9]  = '{32'h0000_0f0f, 32'h0000_0003, 1'b1, 32'h0000_7878, 5};
        vecs[10] = '{32'hffff_ffff, 32'h0000_0020, 1'b1, 32'h0000_0000, 1};
        vecs[11] = '{32'hdead_beef, 32'h0000_0000, 1'b0, 32'hdead_beef, 5};

        #12;
        check("reset_y", Y, 32'd0);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        check("reset_done", {31'd0, DONE}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].lnr,
                   vecs[i].exp_y, vecs[i].exp_lat);
            y_hold = Y;
            @(negedge CLK);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, DONE}, 32'd0);
            check($sformatf("vec%0d_y_kept", i), Y, y_hold);
        end

        // Back-to-back sweep: each new request is driven during the DONE cycle.
        for (int s = 0; s < 32; s++) begin
            run_op($sformatf("sweep%0d", s), 32'h8000_0000, s, 1'b0,
                   32'h8000_0000 >> s, 5);
        end
        @(negedge CLK);
        check("sweep_done_pulse", {31'd0, DONE}, 32'd0);

        // START re-pulsed mid-operation with different operands must be ignored.
        start_op(32'h1234_5678, 32'd4, 1'b1);
        @(posedge CLK); @(negedge CLK);
        D = 32'hffff_ffff; S = 32'd8; LnR = 1'b0; START = 1'b1;
        @(posedge CLK); @(negedge CLK);
        START = 1'b0;
        wait_done(2, lat);
        check("ignore_y", Y, 32'h2345_6780);
        check("ignore_lat", lat, 5);
        y_hold = Y;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (DONE || Y !== y_hold) break;
        end
        check("ignore_no_extra_done", {31'd0, DONE}, 32'd0);
        check("ignore_y_stable", Y, y_hold);

        // Asynchronous reset in the middle of cycle 3 aborts the operation.
        start_op(32'h0000_00ff, 32'd3, 1'b1);
        @(posedge CLK); @(posedge CLK); @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        check("abort_y", Y, 32'd0);
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        check("abort_done", {31'd0, DONE}, 32'd0);
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) break;
        end
        check("abort_no_done", {31'd0, DONE}, 32'd0);
        check("abort_no_busy", {31'd0, BUSY}, 32'd0);
        run_op("after_reset", 32'h0000_0001, 32'd1, 1'b1, 32'h0000_0002, 5);

        // Y must hold while inputs wiggle with START low.
        @(negedge CLK);
        y_hold = Y;
        for (int i = 0; i < 10; i++) begin
            D = $urandom; S = $urandom; LnR = 1'($urandom_range(0, 1)); START = 1'b0;
            @(negedge CLK);
            if (Y !== y_hold || DONE || BUSY) break;
        end
        check("hold_y", Y, 32'h0000_0002);
        check("hold_done", {31'd0, DONE}, 32'd0);
        check("hold_busy", {31'd0, BUSY}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
